dht11_reader: RTL and testbench

//  DHT11 single-wire transaction controller, downstream consumer of the 10 us tick generator.
//  On request it drives the start pulse and decodes the sensor's 40-bit frame by pulse-width

---
 rtl/dht11_reader.sv | 193 +++++++++++++++++++
 tb/tb_dht11_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire transaction controller: issues the host start pulse, decodes the
// 40-bit sensor frame by pulse width in 10 us ticks, and publishes checksum-good readings.
module dht11_reader #(
  parameter int START_TICKS   = 1800,
  parameter int TIMEOUT_TICKS = 20,
  parameter int BIT_THRESH    = 5,
  parameter int CNT_W         = 11
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTick,
  input  logic       iStart,
  inout  wire        ioDht,
  output logic       oBusy,
  output logic       oValid,
  output logic       oError,
  output logic [7:0] oHumInt,
  output logic [7:0] oHumDec,
  output logic [7:0] oTmpInt,
  output logic [7:0] oTmpDec
);

  typedef enum logic [2:0] {
    IDLE,
    START_LOW,
    WAIT_RESP,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [5:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic [7:0]  hum_int_q, hum_int_d;
  logic [7:0]  hum_dec_q, hum_dec_d;
  logic [7:0]  tmp_int_q, tmp_int_d;
  logic [7:0]  tmp_dec_q, tmp_dec_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        rise, fall;
  logic        timed_out;
  logic        bit_val;
  logic [7:0]  sum;
  logic        drive_low;

  // The line idles high through the pull-up, so the synchroniser resets high to avoid a false fall.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= ioDht;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise      = sync2_q & ~prev_q;
  assign fall      = ~sync2_q & prev_q;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_TICKS));
  assign bit_val   = (cnt_q >= CNT_W'(BIT_THRESH));
  assign sum       = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    hum_int_d = hum_int_q;
    hum_dec_d = hum_dec_q;
    tmp_int_d = tmp_int_q;
    tmp_dec_d = tmp_dec_q;

    case (state_q)
      IDLE: begin
        if (iStart) state_d = START_LOW;
      end
      START_LOW: begin
        if (cnt_q == CNT_W'(START_TICKS)) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          state_d = RESP_LOW;
        end
      end
      RESP_LOW: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          state_d = RESP_HIGH;
        end
      end
      RESP_HIGH: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          idx_d   = 6'd0;
          state_d = BIT_LOW;
        end
      end
      BIT_LOW: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (rise) begin
          state_d = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        if (timed_out) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          shift_d = {shift_q[38:0], bit_val};
          idx_d   = idx_q + 6'd1;
          state_d = (idx_q == 6'd39) ? CHECK : BIT_LOW;
        end
      end
      CHECK: begin
        if (sum == shift_q[7:0]) begin
          valid_d   = 1'b1;
          hum_int_d = shift_q[39:32];
          hum_dec_d = shift_q[31:24];
          tmp_int_d = shift_q[23:16];
          tmp_dec_d = shift_q[15:8];
        end else begin
          error_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A state change always clears the counter, so a tick coinciding with an edge is dropped.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (iTick && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      hum_int_q <= '0;
      hum_dec_q <= '0;
      tmp_int_q <= '0;
      tmp_dec_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      hum_int_q <= hum_int_d;
      hum_dec_q <= hum_dec_d;
      tmp_int_q <= tmp_int_d;
      tmp_dec_q <= tmp_dec_d;
    end
  end

  // Gating with iRst releases the line in the very cycle reset asserts.
  assign drive_low = (state_q == START_LOW) && !iRst;
  assign ioDht     = drive_low ? 1'b0 : 1'bz;

  assign oBusy   = (state_q != IDLE);
  assign oValid  = valid_q;
  assign oError  = error_q;
  assign oHumInt = hum_int_q;
  assign oHumDec = hum_dec_q;
  assign oTmpInt = tmp_int_q;
  assign oTmpDec = tmp_dec_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader: a tick-level DHT11 sensor model drives the shared
// pulled-up line while immediate assertions check timing, decoding and pulse behaviour.
module tb_dht11_reader;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iTick = 1'b0;
  logic       iStart;
  wire        dht_line;
  logic       oBusy;
  logic       oValid;
  logic       oError;
  logic [7:0] oHumInt;
  logic [7:0] oHumDec;
  logic [7:0] oTmpInt;
  logic [7:0] oTmpDec;

  logic sensor_low = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tick_count = 0;
  int   phase = 0;

  pullup (dht_line);
  assign dht_line = sensor_low ? 1'b0 : 1'bz;

  dht11_reader dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iTick   (iTick),
    .iStart  (iStart),
    .ioDht   (dht_line),
    .oBusy   (oBusy),
    .oValid  (oValid),
    .oError  (oError),
    .oHumInt (oHumInt),
    .oHumDec (oHumDec),
    .oTmpInt (oTmpInt),
    .oTmpDec (oTmpDec)
  );

  always #5 iClk = ~iClk;

  // One tick every 4 clocks, changed on the falling edge so it is stable at the sampling edge.
  always @(negedge iClk) begin
    phase = (phase == 3) ? 0 : phase + 1;
    iTick = (phase == 0);
    if (phase == 0) tick_count++;
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge iClk); while (iTick !== 1'b1);
    end
    #1;
  endtask

  task automatic doStart(input string tag);
    int   t0;
    logic rel;
    applyStimulus();
    checkOutput({tag, "_busy_after_start"}, oBusy, 1);
    checkOutput({tag, "_line_low"}, dht_line, 0);
    t0  = tick_count;
    rel = 1'b0;
    for (int i = 0; i < 8000 && !rel; i++) begin
      @(posedge iClk);
      #1;
      if (dht_line === 1'b1) rel = 1'b1;
    end
    checkOutput({tag, "_released"}, rel, 1);
    checkOutput({tag, "_low_ticks"}, tick_count - t0, 1800);
  endtask

  // Sensor response then 40 bits MSB-first; ends with the line held low after the last bit.
  task automatic sendFrame(input logic [39:0] frame, input int w0, input int w1,
                           input int rise_off, input int start_at, input int stop_at);
    waitTicks(2);
    sensor_low = 1'b1;
    waitTicks(8);
    sensor_low = 1'b0;
    waitTicks(8);
    for (int i = 0; i < 40; i++) begin
      sensor_low = 1'b1;
      if (i == start_at) begin
        waitTicks(1);
        applyStimulus();
        waitTicks(4);
      end else begin
        waitTicks(5);
      end
      if (rise_off > 0) begin
        repeat (rise_off) @(posedge iClk);
        #1;
      end
      sensor_low = 1'b0;
      if (i == stop_at) begin
        waitTicks(2);
        return;
      end
      waitTicks(frame[39-i] ? w1 : w0);
    end
    sensor_low = 1'b1;
  endtask

  task automatic finishFrame(input string tag, input logic exp_valid, input logic [31:0] exp_data);
    logic v, e, b;
    v = 1'b0;
    e = 1'b0;
    b = 1'b1;
    for (int i = 0; i < 12 && !v && !e; i++) begin
      @(posedge iClk);
      #1;
      v = oValid;
      e = oError;
      b = oBusy;
    end
    checkOutput({tag, "_valid"}, v, exp_valid);
    checkOutput({tag, "_error"}, e, !exp_valid);
    checkOutput({tag, "_busy_at_pulse"}, b, 0);
    checkOutput({tag, "_data"}, {oHumInt, oHumDec, oTmpInt, oTmpDec}, exp_data);
    @(posedge iClk);
    #1;
    checkOutput({tag, "_pulse_one_cycle"}, {oValid, oError}, 0);
    sensor_low = 1'b0;
    waitTicks(3);
  endtask

  initial begin
    iRst       = 1'b1;
    iStart     = 1'b0;
    sensor_low = 1'b0;

    // Reset state
    repeat (3) @(posedge iClk);
    #1;
    checkOutput("t1_line_released", dht_line, 1);
    checkOutput("t1_busy", oBusy, 0);
    checkOutput("t1_pulses", {oValid, oError}, 0);
    checkOutput("t1_data", {oHumInt, oHumDec, oTmpInt, oTmpDec}, 0);
    iRst = 1'b0;
    waitTicks(2);

    // Good frame
    doStart("t2");
    sendFrame(40'h3700190555, 3, 7, 0, -1, -1);
    finishFrame("t2", 1'b1, 32'h37001905);

    // Bad checksum keeps previous data
    doStart("t3");
    sendFrame(40'h38001A0054, 3, 7, 0, -1, -1);
    finishFrame("t3", 1'b0, 32'h37001905);

    // Silent sensor times out one cycle after the 20th tick in WAIT_RESP
    doStart("t4");
    waitTicks(20);
    checkOutput("t4_no_early_error", oError, 0);
    checkOutput("t4_busy_waiting", oBusy, 1);
    @(posedge iClk);
    #1;
    checkOutput("t4_error", oError, 1);
    checkOutput("t4_valid", oValid, 0);
    checkOutput("t4_busy", oBusy, 0);
    checkOutput("t4_line_released", dht_line, 1);
    checkOutput("t4_data_held", {oHumInt, oHumDec, oTmpInt, oTmpDec}, 32'h37001905);
    @(posedge iClk);
    #1;
    checkOutput("t4_error_one_cycle", oError, 0);

    // Threshold widths 4/5 with an ignored iStart during bit 10 low phase
    doStart("t5a");
    sendFrame(40'h0A0B0C0D2E, 4, 5, 0, 10, -1);
    finishFrame("t5a", 1'b1, 32'h0A0B0C0D);

    // Rise coincident with a tick: the tick is dropped, so widths 5/6 count as 4/5
    doStart("t5b");
    sendFrame(40'h1234567814, 5, 6, 1, -1, -1);
    finishFrame("t5b", 1'b1, 32'h12345678);

    // Reset while in BIT_HIGH of bit 3
    doStart("t6b");
    sendFrame(40'h0102030406, 3, 7, 0, -1, 3);
    iRst = 1'b1;
    #1;
    checkOutput("t6b_busy", oBusy, 0);
    checkOutput("t6b_line", dht_line, 1);
    checkOutput("t6b_pulses", {oValid, oError}, 0);
    checkOutput("t6b_data_cleared", {oHumInt, oHumDec, oTmpInt, oTmpDec}, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    waitTicks(2);

    // Reset while the host is driving the start pulse
    applyStimulus();
    waitTicks(100);
    checkOutput("t6c_line_low_mid_start", dht_line, 0);
    iRst = 1'b1;
    #1;
    checkOutput("t6c_line_released", dht_line, 1);
    checkOutput("t6c_busy", oBusy, 0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;
    waitTicks(2);

    // Normal transaction after the aborts
    doStart("t6d");
    sendFrame(40'h3700190555, 3, 7, 0, -1, -1);
    finishFrame("t6d", 1'b1, 32'h37001905);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
